// File: rtl/dual_sq_gen_pkg.sv
// Shared types and constants for the dual-channel square-wave generator.
package dual_sq_gen_pkg;

    // Width of the configuration fields held in the shadow register.
    // Instances must use W <= SqMaxW.
    localparam int unsigned SqMaxW = 32;

    // Smallest period accepted by default, in clk_fs cycles.
    localparam int unsigned DefaultMinPeriod = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPend
    } gen_state_t;

    typedef struct packed {
        logic              en;
        logic [SqMaxW-1:0] period;
        logic [SqMaxW-1:0] high;
        logic [SqMaxW-1:0] phase;
    } sq_cfg_t;

endpackage

// File: rtl/dual_sq_gen_if.sv
// Configuration request channel for dual_sq_gen: valid/ready handshake,
// request fields and the one-cycle reject pulse.
interface dual_sq_gen_if #(
    parameter int unsigned W = 32
) ();

    logic         cfg_valid;
    logic         cfg_ready;
    logic         cfg_en;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_high;
    logic [W-1:0] cfg_phase;
    logic         cfg_err;

    modport master (
        output cfg_valid,
        output cfg_en,
        output cfg_period,
        output cfg_high,
        output cfg_phase,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_en,
        input  cfg_period,
        input  cfg_high,
        input  cfg_phase,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/mod_counter.sv
// W-bit modulo counter: counts 0..modulus-1 while enabled, with a
// synchronous load that takes priority over counting.
module mod_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] modulus_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap_o = (cnt_q == modulus_i - W'(1));
    assign cnt_o  = cnt_q;

    // Next count: load wins, otherwise increment and wrap at modulus-1.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dual_sq_gen.sv
// Dual-channel square-wave generator. fx and fy share period and high time;
// fy lags fx by a programmable number of cycles. Reconfiguration and stop
// requests are deferred to the end of the current fx period so no fx cycle
// is ever truncated.
module dual_sq_gen
    import dual_sq_gen_pkg::*;
#(
    parameter int unsigned W          = 32,
    parameter int unsigned MIN_PERIOD = DefaultMinPeriod
) (
    input  logic         clk_fs,
    input  logic         rst_n,
    dual_sq_gen_if.slave cfg,
    output logic         fx,
    output logic         fy,
    output logic         running,
    output logic         period_tick
);

    gen_state_t   state_q;
    logic [W-1:0] period_q;
    logic [W-1:0] high_q;
    sq_cfg_t      shadow_q;
    logic         fx_q;
    logic         fy_q;
    logic         tick_q;
    logic         err_q;

    logic [W-1:0] cx;
    logic [W-1:0] cy;
    logic         cx_wrap;
    logic         unused_cy_wrap;

    logic         req_acc;
    logic         req_bad;
    logic         req_ok;
    logic         cnt_en;
    logic         cnt_load;
    logic [W-1:0] cy_load_val;

    // Starting Y count so that fy(n) = fx(n-D). D < P is guaranteed by the
    // request check, so P-D never underflows.
    function automatic logic [W-1:0] cy_start(input logic [W-1:0] p, input logic [W-1:0] d);
        return (d == '0) ? '0 : p - d;
    endfunction

    assign cfg.cfg_ready = (state_q != StPend);
    assign cfg.cfg_err   = err_q;

    assign req_acc = cfg.cfg_valid & cfg.cfg_ready;
    assign req_bad = cfg.cfg_en & ((cfg.cfg_period < W'(MIN_PERIOD)) |
                                   (cfg.cfg_high > cfg.cfg_period) |
                                   (cfg.cfg_phase >= cfg.cfg_period));
    assign req_ok  = req_acc & ~req_bad;
    assign cnt_en  = (state_q != StIdle);

    // Counter load on start from idle or on a deferred run request at the boundary.
    always_comb begin
        cnt_load    = 1'b0;
        cy_load_val = '0;
        unique case (state_q)
            StIdle: begin
                if (req_ok && cfg.cfg_en) begin
                    cnt_load    = 1'b1;
                    cy_load_val = cy_start(cfg.cfg_period, cfg.cfg_phase);
                end
            end
            StPend: begin
                if (cx_wrap && shadow_q.en) begin
                    cnt_load    = 1'b1;
                    cy_load_val = cy_start(W'(shadow_q.period), W'(shadow_q.phase));
                end
            end
            default: ;
        endcase
    end

    mod_counter #(
        .W (W)
    ) u_cx (
        .clk_i      (clk_fs),
        .rst_ni     (rst_n),
        .en_i       (cnt_en),
        .load_i     (cnt_load),
        .load_val_i ('0),
        .modulus_i  (period_q),
        .cnt_o      (cx),
        .wrap_o     (cx_wrap)
    );

    mod_counter #(
        .W (W)
    ) u_cy (
        .clk_i      (clk_fs),
        .rst_ni     (rst_n),
        .en_i       (cnt_en),
        .load_i     (cnt_load),
        .load_val_i (cy_load_val),
        .modulus_i  (period_q),
        .cnt_o      (cy),
        .wrap_o     (unused_cy_wrap)
    );

    // FSM, active/shadow configuration and registered waveform outputs.
    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            period_q <= '0;
            high_q   <= '0;
            shadow_q <= '0;
            fx_q     <= 1'b0;
            fy_q     <= 1'b0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= req_acc & req_bad;

            // One register stage from the counters; idle forces both channels low.
            if (state_q == StIdle) begin
                fx_q   <= 1'b0;
                fy_q   <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                fx_q   <= (cx < high_q);
                fy_q   <= (cy < high_q);
                tick_q <= (cx == '0);
            end

            unique case (state_q)
                StIdle: begin
                    if (req_ok && cfg.cfg_en) begin
                        period_q <= cfg.cfg_period;
                        high_q   <= cfg.cfg_high;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    // Latched only; applied at the next boundary even if this is one.
                    if (req_ok) begin
                        shadow_q <= '{en:     cfg.cfg_en,
                                      period: SqMaxW'(cfg.cfg_period),
                                      high:   SqMaxW'(cfg.cfg_high),
                                      phase:  SqMaxW'(cfg.cfg_phase)};
                        state_q  <= StPend;
                    end
                end
                StPend: begin
                    if (cx_wrap) begin
                        if (shadow_q.en) begin
                            period_q <= W'(shadow_q.period);
                            high_q   <= W'(shadow_q.high);
                            state_q  <= StRun;
                        end else begin
                            state_q  <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign fx          = fx_q;
    assign fy          = fy_q;
    assign period_tick = tick_q;
    assign running     = (state_q != StIdle);

endmodule

// File: tb/tb_dual_sq_gen.sv
// Scoreboard bench for dual_sq_gen: the stimulus process pushes the
// hand-derived output word expected after each clock edge; the monitor pops
// one entry per falling edge and compares.
module tb_dual_sq_gen;

    typedef struct {
        string      nm;
        logic [5:0] v;   // {fx, fy, period_tick, running, cfg_ready, cfg_err}
    } exp_t;

    logic clk;
    logic rst_n;
    logic fx;
    logic fy;
    logic running;
    logic period_tick;

    exp_t exp_q[$];
    int   n_vec;
    int   n_bad;

    dual_sq_gen_if #(.W(32)) cfg_if ();

    dual_sq_gen #(
        .W          (32),
        .MIN_PERIOD (2)
    ) dut (
        .clk_fs      (clk),
        .rst_n       (rst_n),
        .cfg         (cfg_if),
        .fx          (fx),
        .fy          (fy),
        .running     (running),
        .period_tick (period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic req(input logic v, input logic en, input int unsigned p,
                       input int unsigned h, input int unsigned d);
        cfg_if.cfg_valid  = v;
        cfg_if.cfg_en     = en;
        cfg_if.cfg_period = p;
        cfg_if.cfg_high   = h;
        cfg_if.cfg_phase  = d;
    endtask

    task automatic expect_now(input string nm, input logic fx_e, input logic fy_e,
                              input logic tk_e, input logic run_e, input logic rdy_e,
                              input logic err_e);
        exp_t e;
        e.nm = nm;
        e.v  = {fx_e, fy_e, tk_e, run_e, rdy_e, err_e};
        exp_q.push_back(e);
    endtask

    // Advance one edge; the entry describes the outputs right after it.
    task automatic step(input string nm, input logic fx_e, input logic fy_e,
                        input logic tk_e, input logic run_e, input logic rdy_e,
                        input logic err_e);
        @(posedge clk);
        #1;
        expect_now(nm, fx_e, fy_e, tk_e, run_e, rdy_e, err_e);
    endtask

    // Steady waveform from hand-written per-cycle patterns; tick at index 0.
    task automatic wave(input string nm, input int n, input string fxp, input string fyp,
                        input int ph, input logic run_e, input logic rdy_e);
        for (int i = 0; i < n; i++) begin
            int k;
            k = (ph + i) % fxp.len();
            step(nm, fxp[k] == 8'h31, fyp[k] == 8'h31, k == 0, run_e, rdy_e, 1'b0);
        end
    endtask

    // Monitor / scoreboard.
    initial begin
        exp_t       e;
        logic [5:0] got;
        n_vec = 0;
        n_bad = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {fx, fy, period_tick, running, cfg_if.cfg_ready, cfg_if.cfg_err};
                n_vec++;
                if (got !== e.v) begin
                    n_bad++;
                    $display("FAIL #%0d %s: {fx,fy,tick,run,rdy,err} got %b required %b",
                             n_vec, e.nm, got, e.v);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        rst_n = 1'b0;
        req(0, 0, 0, 0, 0);
        step("reset0", 0, 0, 0, 0, 1, 0);
        step("reset1", 0, 0, 0, 0, 1, 0);
        rst_n = 1'b1;
        step("idle", 0, 0, 0, 0, 1, 0);

        // Rejected requests from idle, back to back, then a stop in idle.
        req(1, 1, 1, 0, 0);
        step("err_p_lt_min", 0, 0, 0, 0, 1, 1);
        req(1, 1, 5, 6, 0);
        step("err_h_gt_p", 0, 0, 0, 0, 1, 1);
        req(1, 1, 5, 0, 5);
        step("err_d_eq_p", 0, 0, 0, 0, 1, 1);
        req(1, 0, 0, 0, 0);
        step("stop_in_idle", 0, 0, 0, 0, 1, 0);
        req(0, 0, 0, 0, 0);
        step("idle_after_err", 0, 0, 0, 0, 1, 0);

        // P=4 H=2 D=1 from idle.
        req(1, 1, 4, 2, 1);
        step("start_421", 0, 0, 0, 1, 1, 0);
        req(0, 0, 0, 0, 0);
        wave("p4d1", 7, "1100", "0110", 0, 1, 1);

        // Request on the last cycle of a period: deferred one full period.
        req(1, 1, 4, 2, 0);
        step("req_on_wrap", 0, 0, 0, 1, 0, 0);
        req(0, 0, 0, 0, 0);
        wave("p4d1_pend", 3, "1100", "0110", 0, 1, 0);
        step("bound_420", 0, 0, 0, 1, 1, 0);
        wave("p4d0", 5, "1100", "1100", 0, 1, 1);

        // Request in the 2nd cycle of a period: old period completes.
        req(1, 1, 6, 3, 3);
        step("req_633", 1, 1, 0, 1, 0, 0);
        req(0, 0, 0, 0, 0);
        step("pend_633", 0, 0, 0, 1, 0, 0);
        step("bound_633", 0, 0, 0, 1, 1, 0);
        wave("p6d3", 12, "111000", "000111", 0, 1, 1);

        // H=0.
        req(1, 1, 8, 0, 0);
        step("req_h0", 1, 0, 1, 1, 0, 0);
        req(0, 0, 0, 0, 0);
        wave("pend_h0", 4, "111000", "000111", 1, 1, 0);
        step("bound_h0", 0, 1, 0, 1, 1, 0);
        wave("h_zero", 16, "00000000", "00000000", 0, 1, 1);

        // H=P.
        req(1, 1, 8, 8, 0);
        step("req_hp", 0, 0, 1, 1, 0, 0);
        req(0, 0, 0, 0, 0);
        wave("pend_hp", 6, "00000000", "00000000", 1, 1, 0);
        step("bound_hp", 0, 0, 0, 1, 1, 0);
        wave("h_eq_p", 16, "11111111", "11111111", 0, 1, 1);

        // P=10 H=4 D=7, then stop with a second request held while blocked.
        req(1, 1, 10, 4, 7);
        step("req_p10", 1, 1, 1, 1, 0, 0);
        req(0, 0, 0, 0, 0);
        wave("pend_p10", 6, "11111111", "11111111", 1, 1, 0);
        step("bound_p10", 1, 1, 0, 1, 1, 0);
        wave("p10", 13, "1111000000", "1000000111", 0, 1, 1);
        req(1, 0, 0, 0, 0);
        step("req_stop", 1, 0, 0, 1, 0, 0);
        req(1, 1, 4, 2, 0);
        wave("stop_pend", 5, "1111000000", "1000000111", 4, 1, 0);
        step("stop_bound", 0, 1, 0, 0, 1, 0);
        req(0, 0, 0, 0, 0);
        step("stopped", 0, 0, 0, 0, 1, 0);
        step("stopped2", 0, 0, 0, 0, 1, 0);

        // Asynchronous reset while PEND with fx high.
        req(1, 1, 4, 2, 0);
        step("rst_start", 0, 0, 0, 1, 1, 0);
        req(1, 1, 6, 3, 3);
        step("rst_req", 1, 1, 1, 1, 0, 0);
        req(0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        expect_now("async_rst", 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step("after_rst", 0, 0, 0, 0, 1, 0);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d entries left required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dual_sq_gen.md
# dual_sq_gen

Programmable dual-channel square-wave generator driving the `fx`/`fy` inputs of the frequency/phase meter in self-test and calibration builds. Both outputs are derived from `clk_fs` with a configurable period, high time and phase lag of `fy` behind `fx`. Every channel edge is therefore an exact integer number of `clk_fs` cycles, so the meter's counts for frequency, duty and phase have a known expected value.

## Interface
- `W`, default 32: width of period/high/phase fields and internal counters.
- `MIN_PERIOD`, default 2: smallest accepted period in `clk_fs` cycles.
- `clk_fs`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  configuration request.
- `cfg_ready`  out  1  configuration can be accepted this cycle.
- `cfg_en`  in  1  1 = run with the supplied fields; 0 = stop request (fields ignored).
- `cfg_period`  in  W  period P in cycles.
- `cfg_high`  in  W  high time H in cycles, 0..P.
- `cfg_phase`  in  W  lag D of `fy` behind `fx` in cycles, 0..P-1.
- `cfg_err`  out  1  one-cycle pulse: the request was rejected.
- `fx`  out  1  channel X square wave.
- `fy`  out  1  channel Y square wave; `fy(n) = fx(n-D)` in steady state.
- `running`  out  1  generator is in RUN or PEND.
- `period_tick`  out  1  one-cycle pulse aligned with each `fx` cycle start.

## Operation
- Handshake: a request is accepted when `cfg_valid & cfg_ready` are both high at a rising edge. The request is checked in that same cycle.
- Rejection rule: with `cfg_en=1`, a request is rejected if `P < MIN_PERIOD`, `H > P` or `D >= P`.
  - Rejected: `cfg_err` pulses on the next cycle; state and outputs are unchanged.
  - Stop requests (`cfg_en=0`) are never rejected.
- States:
  - IDLE: outputs low, `cfg_ready=1`.
    - Valid run request → RUN with X counter `cx=0` and Y counter `cy=(P-D) mod P`.
    - Stop request → stays in IDLE.
  - RUN: `cfg_ready=1`.
    - Each cycle, `cx` and `cy` increment modulo P.
    - `fx <= (cx < H)`, `fy <= (cy < H)`.
    - An accepted request (run or stop) is latched into a shadow register → PEND.
  - PEND: `cfg_ready=0`; counting continues with the old configuration.
    - At the boundary (`cx == P_old-1`), a pending run request loads the new P/H/D, sets `cx=0` and `cy=(P_new-D_new) mod P_new`, and returns to RUN.
    - At the boundary, a pending stop goes to IDLE.
    - This way `fx` never produces a truncated or glitched cycle.
- Edge cases:
  - `H=0`: `fx` and `fy` constantly low.
  - `H=P`: `fx` and `fy` constantly high.
  - `D=0`: `fy` identical to `fx`.
- Arithmetic: counters are W bits and compare unsigned. `P-D` is computed in W bits; it is safe because `D<P`.
- `period_tick` is registered from `cx==0`.

## Timing
- Reset values: `fx=0`, `fy=0`, `cfg_ready=1`, `cfg_err=0`, `running=0`, `period_tick=0`; state IDLE; counters and shadow register 0.
- Start from IDLE: accepted at edge t.
  - `cx=0` holds after edge t.
  - After edge t+1: `fx` shows the value for `cx=0` and `period_tick=1`.
  - `running=1` from edge t.
- Output latency: one register stage from the counters to `fx`/`fy`/`period_tick`. `fx` and `fy` change only on `clk_fs` edges.
- Reconfiguration boundary: the first cycle of the new configuration is the cycle immediately after the last old cycle. `fx` sequences abut with no gap.
- Stop: after the boundary edge, `running=0`. `fx` and `fy` are 0 one edge later.
- Simultaneous events: a request arriving in the same cycle as a boundary while in RUN is only latched. It takes effect at the next boundary, not the current one.
- Reset mid-operation: asynchronous; all outputs go to reset values immediately; a pending shadow request is discarded.

## Structure
- Package `dual_sq_gen_pkg`:
  - state enum `gen_state_t` {IDLE, RUN, PEND};
  - struct `sq_cfg_t` {en, period, high, phase};
  - constant for the default `MIN_PERIOD`.
- Sub-module `mod_counter` (W-bit modulo-P counter with synchronous load value and wrap flag), instantiated twice, once for `cx` and once for `cy`.
- Top level holds the FSM, the shadow register, the request check and the output registers.

## Test plan
- P=4, H=2, D=1 from IDLE → after `period_tick`, `fx` repeats 1,1,0,0 and `fy` repeats 0,1,1,0; `period_tick` every 4th cycle.
- P=1, H=0, D=0, then P=5, H=6, then P=5, D=5 → three `cfg_err` pulses; state stays IDLE; `fx=fy=0`; `cfg_ready` stays 1.
- Running P=4, H=2, D=0; in the 2nd cycle of a period, request P=6, H=3, D=3 → `cfg_ready` low until the boundary; old pattern 1,1,0,0 completes, then `fx` is 1,1,1,0,0,0 and `fy` is 0,0,0,1,1,1.
- P=8, H=0 and P=8, H=8 → `fx`/`fy` constantly 0 and constantly 1; `period_tick` still every 8 cycles.
- Running P=10; stop request → `fx` completes its current period, `running` falls at the boundary, then `fx=fy=0`; a second request is blocked (`cfg_ready=0`) until then.
- Assert `rst_n` low mid-period in PEND → outputs 0 and `cfg_ready=1` with no clock edge; after release, state is IDLE and the pending request is lost.
